// File: rtl/instruction_fetch_ctrl.sv
// Fetch sequencer: owns PC and IR, hands instructions over a valid/ready pair.
// Define IFETCH_ADDR_FAULT_EN to trap fetches at or beyond MEM_DEPTH.
module instruction_fetch_ctrl #(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int          MEM_DEPTH = 256,
  parameter int          COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0]  ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic [COUNT_W-1:0] fetch_count,
  output logic               fault
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
`ifdef IFETCH_ADDR_FAULT_EN
    ,
    FAULT
`endif
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [DATA_W-1:0]   ir_n;
  logic [ADDR_W-1:0]   ir_pc_n;
  logic                ir_valid_n;
  logic [COUNT_W-1:0]  cnt_n;
  logic                fault_n;
  logic                fault_q;
  logic                fetch_ok;

`ifdef IFETCH_ADDR_FAULT_EN
  assign fetch_ok = 32'(pc) < 32'(MEM_DEPTH);
`else
  assign fetch_ok = 1'b1;
  // Depth only matters for the range check.
  if (MEM_DEPTH < 1) begin : g_depth_unused
  end
`endif

  assign mem_addr = pc;
  assign busy     = (state != IDLE);
  assign fault    = fault_q;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    cnt_n      = fetch_count;
    fault_n    = fault_q;
    unique case (state)
      IDLE: begin
        if (halt_req) begin
          state_n = IDLE;
        end else if (redirect_valid) begin
          pc_n = redirect_pc;
        end else if (start) begin
          state_n = FETCH;
        end
      end
      FETCH, HOLD: begin
        if (halt_req) begin
          ir_valid_n = 1'b0;
          state_n    = IDLE;
        end else if (redirect_valid) begin
          pc_n       = redirect_pc;
          ir_valid_n = 1'b0;
          state_n    = FETCH;
        end else if (state == HOLD) begin
          if (ir_ready && ir_valid) begin
            ir_valid_n = 1'b0;
            state_n    = FETCH;
          end
        end else if (fetch_ok) begin
          ir_n       = mem_rdata;
          ir_pc_n    = pc;
          pc_n       = pc + 1'b1;
          ir_valid_n = 1'b1;
          if (fetch_count != '1) begin
            cnt_n = fetch_count + 1'b1;
          end
          state_n = HOLD;
        end else begin
`ifdef IFETCH_ADDR_FAULT_EN
          fault_n    = 1'b1;
          ir_valid_n = 1'b0;
          state_n    = FAULT;
`endif
        end
      end
`ifdef IFETCH_ADDR_FAULT_EN
      // Only reset leaves a fault.
      FAULT: state_n = FAULT;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      fetch_count <= '0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ir          <= ir_n;
      ir_pc       <= ir_pc_n;
      ir_valid    <= ir_valid_n;
      fetch_count <= cnt_n;
      fault_q     <= fault_n;
    end
  end

endmodule
